// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver and the receive FIFO.
package uart_pkg;

    localparam int unsigned UART_DATA_W = 8;

    // One buffered frame: received byte plus its line-error flags.
    typedef struct packed {
        logic                   stop_err;
        logic                   parity_err;
        logic [UART_DATA_W-1:0] data;
    } rx_entry_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Host-side read bus of the UART receive FIFO.
// master: the host (pops, clears overrun); slave: the FIFO.
interface uart_rx_fifo_if #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DATA_W = 8
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic              rd_en;
    logic              clear_overrun;
    logic [DATA_W-1:0] rd_data;
    logic              rd_parity_err;
    logic              rd_stop_err;
    logic              empty;
    logic              full;
    logic [AW:0]       count;
    logic              overrun;

    modport master (
        output rd_en,
        output clear_overrun,
        input  rd_data,
        input  rd_parity_err,
        input  rd_stop_err,
        input  empty,
        input  full,
        input  count,
        input  overrun
    );

    modport slave (
        input  rd_en,
        input  clear_overrun,
        output rd_data,
        output rd_parity_err,
        output rd_stop_err,
        output empty,
        output full,
        output count,
        output overrun
    );

endinterface

// File: rtl/uart_fifo_mem.sv
// Storage array for the receive FIFO: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  rx_entry_t                wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output rx_entry_t                rdata_o
);

    rx_entry_t mem_q [DEPTH];

    // Write the accepted frame into its slot.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Head entry is read combinationally for first-word-fall-through.
    always_comb begin
        rdata_o = mem_q[raddr_i];
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: captures frames on the rising edge of data_ready into a
// first-word-fall-through FIFO, reports lost frames through a sticky overrun.
// Optional feature macro UART_RX_FIFO_DROP_ERR_EN: frames with parity or stop
// errors are discarded and counted in err_cnt (saturating at 255).
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DATA_W = UART_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_out,
    input  logic              data_ready,
    input  logic              parity_error,
    input  logic              stop_error,
    uart_rx_fifo_if.slave     host
`ifdef UART_RX_FIFO_DROP_ERR_EN
    ,
    output logic [7:0]        err_cnt
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overrun_q, overrun_d;
    logic          dr_hist_q, dr_hist_d;

    logic          push_req;
    logic          push_ev;
    logic          pop_ev;
    logic          push_acc;
    logic          drop_full;
    logic          empty_w;
    logic          full_w;
    rx_entry_t     wr_entry;
    rx_entry_t     head_entry;

`ifdef UART_RX_FIFO_DROP_ERR_EN
    logic [7:0]    err_cnt_q, err_cnt_d;
    logic          drop_err;
`endif

    // Push qualification, pop qualification and occupancy flags.
    always_comb begin
        empty_w  = (count_q == '0);
        full_w   = (count_q == (AW+1)'(DEPTH));
        push_req = data_ready & ~dr_hist_q;
`ifdef UART_RX_FIFO_DROP_ERR_EN
        drop_err = push_req & (parity_error | stop_error);
        push_ev  = push_req & ~(parity_error | stop_error);
`else
        push_ev  = push_req;
`endif
        pop_ev    = host.rd_en & ~empty_w;
        // A pop in the same cycle frees a slot, so a push while full still fits.
        push_acc  = push_ev & (~full_w | pop_ev);
        drop_full = push_ev & full_w & ~pop_ev;
        wr_entry  = '{stop_err:   stop_error,
                      parity_err: parity_error,
                      data:       UART_DATA_W'(data_out)};
    end

    // Next-state for pointers, occupancy, overrun and data_ready history.
    always_comb begin
        dr_hist_d = data_ready;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;

        if (push_acc) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ev) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push_acc && !pop_ev) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!push_acc && pop_ev) begin
            count_d = count_q - (AW+1)'(1);
        end

        // A new drop wins over a simultaneous clear.
        if (drop_full) begin
            overrun_d = 1'b1;
        end else if (host.clear_overrun) begin
            overrun_d = 1'b0;
        end
    end

    // State registers; history resets high so a level held through reset is ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            dr_hist_q <= 1'b1;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
            dr_hist_q <= dr_hist_d;
        end
    end

`ifdef UART_RX_FIFO_DROP_ERR_EN
    // Saturating count of frames discarded for line errors.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (drop_err && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // Error counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_cnt_q <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

    uart_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (push_acc),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry),
        .raddr_i (rd_ptr_q),
        .rdata_o (head_entry)
    );

    // Host outputs: head entry when non-empty, zeros otherwise.
    always_comb begin
        host.empty         = empty_w;
        host.full          = full_w;
        host.count         = count_q;
        host.overrun       = overrun_q;
        host.rd_data       = '0;
        host.rd_parity_err = 1'b0;
        host.rd_stop_err   = 1'b0;
        if (!empty_w) begin
            host.rd_data       = DATA_W'(head_entry.data);
            host.rd_parity_err = head_entry.parity_err;
            host.rd_stop_err   = head_entry.stop_err;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo with a scoreboard queue of expected entries.
module tb_uart_rx_fifo;

    localparam int unsigned DEPTH = 16;

    logic       clk;
    logic       reset;
    logic [7:0] data_out;
    logic       data_ready;
    logic       parity_error;
    logic       stop_error;
`ifdef UART_RX_FIFO_DROP_ERR_EN
    logic [7:0] err_cnt;
`endif

    uart_rx_fifo_if #(.DEPTH(DEPTH), .DATA_W(8)) host_if ();

    uart_rx_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .data_out     (data_out),
        .data_ready   (data_ready),
        .parity_error (parity_error),
        .stop_error   (stop_error),
        .host         (host_if)
`ifdef UART_RX_FIFO_DROP_ERR_EN
        ,
        .err_cnt      (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [9:0] sb_q[$];   // {stop, parity, data}
    logic model_ovr = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: decide whether a frame is stored, dropped for errors, or lost to overrun.
    task automatic model_push(input logic [7:0] d, input logic p, input logic s,
                              input logic pop_same);
`ifdef UART_RX_FIFO_DROP_ERR_EN
        if (p || s) return;
`endif
        if (sb_q.size() < DEPTH || pop_same) sb_q.push_back({s, p, d});
        else model_ovr = 1'b1;
    endtask

    task automatic push_frame(input logic [7:0] d, input logic p, input logic s);
        data_out = d; parity_error = p; stop_error = s; data_ready = 1'b1;
        model_push(d, p, s, 1'b0);
        tick();
        data_ready = 1'b0; parity_error = 1'b0; stop_error = 1'b0;
        tick();
    endtask

    task automatic pop_and_check(input string tag);
        logic [9:0] exp;
        n_cmp++;
        if (sb_q.size() == 0) begin
            n_bad++;
            $display("FAIL %s: scoreboard empty, cannot check head", tag);
            return;
        end
        exp = sb_q.pop_front();
        if ({host_if.rd_stop_err, host_if.rd_parity_err, host_if.rd_data} !== exp
            || host_if.empty !== 1'b0) begin
            n_bad++;
            $display("FAIL %s: head got s=%b p=%b d=%h empty=%b, want s=%b p=%b d=%h empty=0",
                     tag, host_if.rd_stop_err, host_if.rd_parity_err, host_if.rd_data,
                     host_if.empty, exp[9], exp[8], exp[7:0]);
        end
        host_if.rd_en = 1'b1;
        tick();
        host_if.rd_en = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++;
        if (host_if.count !== 5'd0 || host_if.empty !== 1'b1 || host_if.full !== 1'b0
            || host_if.overrun !== 1'b0 || host_if.rd_data !== 8'h00) begin
            n_bad++;
            $display("FAIL reset: count=%0d empty=%b full=%b ovr=%b rd=%h, want 0 1 0 0 00",
                     host_if.count, host_if.empty, host_if.full, host_if.overrun,
                     host_if.rd_data);
        end
    endtask

    task automatic test_basic();
        push_frame(8'h55, 1'b0, 1'b0);
        push_frame(8'hA3, 1'b0, 1'b0);
        n_cmp++;
        if (host_if.count !== 5'd2) begin
            n_bad++;
            $display("FAIL basic_count: got %0d want 2", host_if.count);
        end
        pop_and_check("basic_first");
        pop_and_check("basic_second");
        n_cmp++;
        if (host_if.empty !== 1'b1 || host_if.rd_data !== 8'h00) begin
            n_bad++;
            $display("FAIL basic_empty: empty=%b rd=%h want 1 00", host_if.empty,
                     host_if.rd_data);
        end
    endtask

    task automatic test_held_level();
        data_out = 8'h3C; data_ready = 1'b1;
        model_push(8'h3C, 1'b0, 1'b0, 1'b0);
        repeat (5) tick();
        data_ready = 1'b0;
        tick();
        n_cmp++;
        if (host_if.count !== 5'd1) begin
            n_bad++;
            $display("FAIL held_level_count: got %0d want 1", host_if.count);
        end
        pop_and_check("held_level_data");
    endtask

    task automatic test_overrun();
        for (int i = 0; i <= 16; i++) push_frame(8'(i), 1'b0, 1'b0);
        n_cmp++;
        if (host_if.full !== 1'b1 || host_if.count !== 5'd16
            || host_if.overrun !== model_ovr || model_ovr !== 1'b1) begin
            n_bad++;
            $display("FAIL overrun_full: full=%b count=%0d ovr=%b want 1 16 1",
                     host_if.full, host_if.count, host_if.overrun);
        end
        for (int i = 0; i < 16; i++) pop_and_check($sformatf("overrun_pop%0d", i));
        n_cmp++;
        if (host_if.overrun !== 1'b1 || host_if.empty !== 1'b1) begin
            n_bad++;
            $display("FAIL overrun_sticky: ovr=%b empty=%b want 1 1", host_if.overrun,
                     host_if.empty);
        end
        host_if.clear_overrun = 1'b1;
        tick();
        host_if.clear_overrun = 1'b0;
        model_ovr = 1'b0;
        n_cmp++;
        if (host_if.overrun !== 1'b0) begin
            n_bad++;
            $display("FAIL overrun_clear: got %b want 0", host_if.overrun);
        end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 16; i++) push_frame(8'h20 + 8'(i), 1'b0, 1'b0);
        // Check head, then push 0x77 and pop in the same cycle.
        n_cmp++;
        if (host_if.rd_data !== sb_q[0][7:0]) begin
            n_bad++;
            $display("FAIL fullpp_head: got %h want %h", host_if.rd_data, sb_q[0][7:0]);
        end
        void'(sb_q.pop_front());
        model_push(8'h77, 1'b0, 1'b0, 1'b1);
        data_out = 8'h77; data_ready = 1'b1; host_if.rd_en = 1'b1;
        tick();
        data_ready = 1'b0; host_if.rd_en = 1'b0;
        tick();
        n_cmp++;
        if (host_if.count !== 5'd16 || host_if.overrun !== 1'b0) begin
            n_bad++;
            $display("FAIL fullpp_state: count=%0d ovr=%b want 16 0", host_if.count,
                     host_if.overrun);
        end
        // Drop and clear in the same cycle: the drop must win.
        model_push(8'h99, 1'b0, 1'b0, 1'b0);
        data_out = 8'h99; data_ready = 1'b1; host_if.clear_overrun = 1'b1;
        tick();
        data_ready = 1'b0; host_if.clear_overrun = 1'b0;
        tick();
        n_cmp++;
        if (host_if.overrun !== 1'b1 || host_if.count !== 5'd16) begin
            n_bad++;
            $display("FAIL set_wins: ovr=%b count=%0d want 1 16", host_if.overrun,
                     host_if.count);
        end
        for (int i = 0; i < 16; i++) pop_and_check($sformatf("fullpp_pop%0d", i));
        host_if.clear_overrun = 1'b1;
        tick();
        host_if.clear_overrun = 1'b0;
        model_ovr = 1'b0;
    endtask

    task automatic test_errors();
        push_frame(8'h81, 1'b1, 1'b0);
        push_frame(8'h82, 1'b0, 1'b1);
`ifdef UART_RX_FIFO_DROP_ERR_EN
        n_cmp++;
        if (host_if.count !== 5'd0 || err_cnt !== 8'd2) begin
            n_bad++;
            $display("FAIL err_drop: count=%0d err_cnt=%0d want 0 2", host_if.count, err_cnt);
        end
`else
        n_cmp++;
        if (host_if.count !== 5'd2) begin
            n_bad++;
            $display("FAIL err_store_count: got %0d want 2", host_if.count);
        end
        pop_and_check("err_parity_entry");
        pop_and_check("err_stop_entry");
`endif
    endtask

    task automatic test_reset_midstream();
        push_frame(8'h11, 1'b0, 1'b0);
        push_frame(8'h12, 1'b0, 1'b0);
        data_out = 8'h13; data_ready = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        sb_q.delete();
        n_cmp++;
        if (host_if.count !== 5'd0 || host_if.empty !== 1'b1 || host_if.overrun !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_async: count=%0d empty=%b ovr=%b want 0 1 0",
                     host_if.count, host_if.empty, host_if.overrun);
        end
        tick();
        reset = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if (host_if.count !== 5'd0) begin
            n_bad++;
            $display("FAIL reset_held_level: got %0d want 0", host_if.count);
        end
        data_ready = 1'b0;
        tick();
        data_out = 8'h5A; data_ready = 1'b1;
        model_push(8'h5A, 1'b0, 1'b0, 1'b0);
        tick();
        data_ready = 1'b0;
        tick();
        n_cmp++;
        if (host_if.count !== 5'd1) begin
            n_bad++;
            $display("FAIL reset_new_edge: got %0d want 1", host_if.count);
        end
        pop_and_check("reset_new_edge_data");
    endtask

    initial begin
        reset = 1'b0;
        data_out = 8'h00; data_ready = 1'b0; parity_error = 1'b0; stop_error = 1'b0;
        host_if.rd_en = 1'b0; host_if.clear_overrun = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        test_reset();
        test_basic();
        test_held_level();
        test_overrun();
        test_full_push_pop();
        test_errors();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive buffer sitting directly downstream of the UART receiver.
- Captures each received byte on the receiver's data_ready strobe, together with its parity_error and stop_error flags.
- Holds the bytes in a first-word-fall-through (FWFT) FIFO.
- The host side pops entries at its own pace. Loss of frames is reported through a sticky overrun flag.

Parameters:
- DEPTH, 16, number of entries; power of 2, minimum 2.
- DATA_W, 8, data bits per frame; must equal the receiver's data_out width.
- AW, $clog2(DEPTH), derived pointer width; not overridable.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- data_out  input  DATA_W  received byte from the UART receiver.
- data_ready  input  1  receiver frame-complete indication; may stay high for more than one cycle.
- parity_error  input  1  parity flag for the current data_out.
- stop_error  input  1  stop-bit flag for the current data_out.
- rd_en  input  1  pop request from the host.
- rd_data  output  DATA_W  head entry data.
- rd_parity_err  output  1  head entry parity flag.
- rd_stop_err  output  1  head entry stop flag.
- empty  output  1  FIFO holds 0 entries.
- full  output  1  FIFO holds DEPTH entries.
- count  output  AW+1  current occupancy, 0..DEPTH.
- overrun  output  1  sticky: at least one frame was lost.
- clear_overrun  input  1  clears overrun.

Behaviour:
- Reset (asserted low, acts immediately): wr_ptr=rd_ptr=0, count=0, empty=1, full=0, overrun=0, data_ready history register=1. Storage array is not reset.
- Because the history register resets to 1, a data_ready level held through reset release is not pushed.
- Push event: data_ready=1 AND history=0 (rising edge). History register updates to data_ready every cycle.
- Stored word is {stop_error, parity_error, data_out}, all sampled in the push cycle.
- Pop event: rd_en=1 AND empty=0. Pop with empty=1 is ignored; no state changes.
- FWFT: rd_data, rd_parity_err and rd_stop_err show the head entry whenever empty=0.
  - When empty=1 these outputs are driven to 0.
  - A pushed entry becomes visible the cycle after the push edge (1-cycle latency).
- Occupancy updates:
  - Push only (not full): write at wr_ptr, wr_ptr+1, count+1.
  - Pop only: rd_ptr+1, count-1.
  - Push and pop, not empty and not full: both pointers advance; count unchanged.
  - Push and pop while full: the pop frees a slot, so the push is accepted; count stays DEPTH; no overrun.
  - Push and pop while empty: push accepted; pop ignored; count becomes 1.
  - Push while full with no pop: frame dropped, pointers unchanged, overrun<=1.
- Pointers wrap modulo DEPTH (natural AW-bit rollover). full and empty are derived from count.
- overrun is cleared by clear_overrun=1. If a new drop occurs in the same cycle as clear_overrun, set wins and overrun stays 1.
- No combinational path from data_ready to any output. rd_* outputs depend combinationally only on registered state.

Optional Feature:
- Macro: UART_RX_FIFO_DROP_ERR_EN.
- Defined:
  - Push events with parity_error=1 or stop_error=1 are discarded and never stored.
  - An extra output port err_cnt (8 bits, reset 0) counts discarded frames and saturates at 255.
  - A discarded frame never sets overrun, even when the FIFO is full.
- Undefined: errored frames are stored with their flags; err_cnt port is absent.

Decomposition:
- Package uart_pkg:
  - constant UART_DATA_W=8.
  - typedef rx_entry_t, a packed struct {logic stop_err; logic parity_err; logic [UART_DATA_W-1:0] data}.
  - This block and the receiver share the package.
- One sub-module, uart_fifo_mem: dual-pointer storage array of rx_entry_t, with synchronous write and asynchronous read at rd_ptr.
- Edge detection, count/flag logic and overrun stay in uart_rx_fifo.

Test Plan:
- Reset, then data_ready pulses with data_out=0x55 then 0xA3, no errors -> count=2; rd_data=0x55; after one rd_en, rd_data=0xA3; after a second, empty=1 and rd_data=0.
- data_ready held high 5 cycles with data_out=0x3C -> exactly one entry pushed; count=1.
- DEPTH=16: push 17 frames 0x00..0x10 with no pops -> full=1; 17th frame dropped; overrun=1; pop all 16 -> values 0x00..0x0F in order. clear_overrun -> overrun=0.
- Fill to full, then assert a data_ready edge (0x77) and rd_en in the same cycle -> count stays 16, overrun stays 0, 0x77 is the last entry read.
- Push 0x81 with parity_error=1, then 0x82 with stop_error=1:
  - Macro undefined -> rd_parity_err=1 on the first entry, rd_stop_err=1 on the second.
  - Macro defined -> count=0, err_cnt=2.
- Push 3 frames, assert reset low mid-stream (with data_ready high across release) -> count=0, empty=1, overrun=0 immediately; no push after release until data_ready falls and rises again.
